// File: rtl/la_trigger_capture.sv
// la_trigger_capture: triggered 4-channel sample capture for the logic-analyzer display.
// Samples logic_in_i once per divider tick into a Depth-entry circular buffer. After an arm
// request it collects PreTrig samples of history, then waits for the selected edge (or an
// auto timeout), fills the rest of the frame and freezes it for the column renderer.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   logic_in_i[3:0]     channel inputs
//   speed_switch_i      sample rate select (0: DivSlow, 1: DivFast clocks per sample)
//   arm_i               pulse: start a new capture (aborts any capture in progress)
//   trig_ch_i[1:0]      trigger channel; trig_rising_i selects rising (1) / falling (0)
//   auto_mode_i         force a trigger after AutoTimeout waiting samples
//   continuous_i        re-arm on frame_ack_i when a frame is complete
//   frame_ack_i         pulse: renderer finished drawing the frame
//   rd_addr_i[6:0]      column index, 0 = oldest sample
//   rd_data_o[3:0]      sample at rd_addr_i, 0 when out of range or no frozen frame
//   frame_valid_o       frozen frame available
//   forced_o            last trigger came from the auto timeout
//   cap_state_o[2:0]    FSM state: 0 idle, 1 pre, 2 wait, 3 post, 4 done
module la_trigger_capture #(
    parameter int unsigned Depth       = 96,
    parameter int unsigned PreTrig     = 32,
    parameter int unsigned DivSlow     = 50000,
    parameter int unsigned DivFast     = 10000,
    parameter int unsigned AutoTimeout = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] logic_in_i,
    input  logic       speed_switch_i,
    input  logic       arm_i,
    input  logic [1:0] trig_ch_i,
    input  logic       trig_rising_i,
    input  logic       auto_mode_i,
    input  logic       continuous_i,
    input  logic       frame_ack_i,
    input  logic [6:0] rd_addr_i,
    output logic [3:0] rd_data_o,
    output logic       frame_valid_o,
    output logic       forced_o,
    output logic [2:0] cap_state_o
);

    localparam int unsigned PtrW   = 7;
    localparam int unsigned DivMax = (DivSlow > DivFast) ? DivSlow : DivFast;
    localparam int unsigned DivW   = (DivMax < 2) ? 1 : $clog2(DivMax);
    localparam int unsigned CntMax = (AutoTimeout > Depth) ? AutoTimeout : Depth;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StWait = 3'd2,
        StPost = 3'd3,
        StDone = 3'd4
    } state_e;

    // ---------------- sample-rate divider ----------------
    logic [DivW-1:0] div_q;
    logic [DivW-1:0] div_last;
    logic            speed_q;
    logic            spd_chg;
    logic            tick;

    assign div_last = speed_switch_i ? DivW'(DivFast - 1) : DivW'(DivSlow - 1);
    assign spd_chg  = (speed_switch_i != speed_q);
    assign tick     = !spd_chg && (div_q == div_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            speed_q <= 1'b0;
        end else begin
            speed_q <= speed_switch_i;
            if (spd_chg || tick) div_q <= '0;
            else                 div_q <= div_q + 1'b1;
        end
    end

    // ---------------- sampled history and edge detect ----------------
    // sample_q holds the previous tick's sample; the current one is logic_in_i at the tick.
    logic [3:0] sample_q;
    logic       edge_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     sample_q <= '0;
        else if (tick) sample_q <= logic_in_i;
    end

    always_comb begin
        edge_hit = 1'b0;
        if (tick) begin
            if (trig_rising_i) edge_hit = !sample_q[trig_ch_i] && logic_in_i[trig_ch_i];
            else               edge_hit = sample_q[trig_ch_i] && !logic_in_i[trig_ch_i];
        end
    end

    // ---------------- capture FSM ----------------
    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   start_q;
    logic              frame_valid_q;
    logic              forced_q;

    // A restart is folded in before the tick logic so that a tick in the same cycle
    // becomes the first PRE write at index 0.
    logic              restart;
    state_e            st_eff;
    logic [CntW-1:0]   cnt_eff;
    logic [PtrW-1:0]   ptr_eff;
    logic [PtrW-1:0]   ptr_inc;
    logic [PtrW-1:0]   trig_start;
    logic              wr_en;

    always_comb begin
        restart    = arm_i || ((state_q == StDone) && frame_ack_i && continuous_i);
        st_eff     = restart ? StPre : state_q;
        cnt_eff    = restart ? '0 : cnt_q;
        ptr_eff    = restart ? '0 : wr_ptr_q;
        ptr_inc    = (ptr_eff == PtrW'(Depth - 1)) ? '0 : ptr_eff + 1'b1;
        trig_start = (ptr_eff >= PtrW'(PreTrig)) ? ptr_eff - PtrW'(PreTrig)
                                                 : ptr_eff + PtrW'(Depth - PreTrig);
        wr_en      = tick && ((st_eff == StPre) || (st_eff == StWait) || (st_eff == StPost));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            start_q       <= '0;
            frame_valid_q <= 1'b0;
            forced_q      <= 1'b0;
        end else begin
            state_q  <= st_eff;
            cnt_q    <= cnt_eff;
            wr_ptr_q <= ptr_eff;
            if (restart) frame_valid_q <= 1'b0;
            if (wr_en) begin
                wr_ptr_q <= ptr_inc;
                unique case (st_eff)
                    StPre: begin
                        if (cnt_eff == CntW'(PreTrig - 1)) begin
                            state_q <= StWait;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_eff + 1'b1;
                        end
                    end
                    StWait: begin
                        // cnt saturates so a late auto_mode enable triggers on the next tick
                        if (edge_hit || (auto_mode_i && (cnt_eff == CntW'(AutoTimeout - 1)))) begin
                            state_q  <= StPost;
                            cnt_q    <= '0;
                            start_q  <= trig_start;
                            forced_q <= !edge_hit;
                        end else if (cnt_eff != CntW'(AutoTimeout - 1)) begin
                            cnt_q <= cnt_eff + 1'b1;
                        end
                    end
                    StPost: begin
                        if (cnt_eff == CntW'(Depth - PreTrig - 2)) begin
                            state_q       <= StDone;
                            frame_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_eff + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- sample buffer (no reset, contents don't-care) ----------------
    logic [3:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[ptr_eff] <= logic_in_i;
    end

    // ---------------- frame read-out ----------------
    logic [PtrW:0]   rd_sum;
    logic [PtrW:0]   rd_wrap;
    logic [PtrW-1:0] rd_idx;

    always_comb begin
        rd_sum    = {1'b0, start_q} + {1'b0, rd_addr_i};
        rd_wrap   = rd_sum - (PtrW + 1)'(Depth);
        rd_idx    = (rd_sum >= (PtrW + 1)'(Depth)) ? rd_wrap[PtrW-1:0] : rd_sum[PtrW-1:0];
        rd_data_o = '0;
        if (frame_valid_q && (state_q == StDone) && (rd_addr_i < PtrW'(Depth))) begin
            rd_data_o = mem_q[rd_idx];
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign forced_o      = forced_q;
    assign cap_state_o   = state_q;

endmodule

// File: tb/tb_la_trigger_capture.sv
`timescale 1ns/1ps
module tb_la_trigger_capture;

    localparam int Div = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] logic_in;
    logic       speed_switch;
    logic       arm;
    logic [1:0] trig_ch;
    logic       trig_rising;
    logic       auto_mode;
    logic       continuous;
    logic       frame_ack;
    logic [6:0] rd_addr;
    logic [3:0] rd_data;
    logic       frame_valid;
    logic       forced;
    logic [2:0] cap_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];

    la_trigger_capture #(
        .Depth(96), .PreTrig(32), .DivSlow(8), .DivFast(Div), .AutoTimeout(256)
    ) dut (
        .clk_i(clk), .rst_i(rst), .logic_in_i(logic_in), .speed_switch_i(speed_switch),
        .arm_i(arm), .trig_ch_i(trig_ch), .trig_rising_i(trig_rising),
        .auto_mode_i(auto_mode), .continuous_i(continuous), .frame_ack_i(frame_ack),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .frame_valid_o(frame_valid),
        .forced_o(forced), .cap_state_o(cap_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus patterns, bit order {ch3, ch2, ch1, ch0}.
    function automatic logic [3:0] gen(input int pat, input int i);
        logic [31:0] u;
        u = i;
        case (pat)
            0:       return 4'h0;
            1:       return {u[3], u[1], (i >= 49), u[0]};
            2:       return {u[4], (i >= 100), u[2], u[0]};
            3:       return {u[5], u[1], u[0], (i >= 232)};
            default: return {u[0], u[3], u[1], (i >= 40)};
        endcase
    endfunction

    // Trigger model: sample index of the trigger (counted from the arm), and whether forced.
    task automatic find_trig(input int pat, input int ch, input bit rising, input bit auto_m,
                             output int t, output bit frc);
        logic [3:0] p;
        logic [3:0] c;
        t   = -1;
        frc = 1'b0;
        for (int i = 32; i < 32 + 256; i++) begin
            p = gen(pat, i - 1);
            c = gen(pat, i);
            if (rising ? (!p[ch] && c[ch]) : (p[ch] && !c[ch])) begin
                t = i;
                return;
            end
            if (auto_m && i == 32 + 255) begin
                t   = i;
                frc = 1'b1;
                return;
            end
        end
    endtask

    task automatic push_frame(input int pat, input int t);
        for (int k = 0; k < 96; k++) exp_q.push_back(gen(pat, t - 32 + k));
        exp_q.push_back(4'h0);  // rd_addr 96
        exp_q.push_back(4'h0);  // rd_addr 127
    endtask

    // One sample period; called and returns #1 after a tick edge. start: 1 arm,
    // 2 ack expecting restart, 3 ack expecting the frame to be held.
    task automatic tick(input logic [3:0] v, input int start);
        logic_in  = v;
        arm       = (start == 1);
        frame_ack = (start >= 2);
        @(posedge clk); #1;
        arm       = 1'b0;
        frame_ack = 1'b0;
        if (start == 1 || start == 2) begin
            check("restart_state", cap_state, 1);
            check("restart_fv", frame_valid, 0);
            check("restart_rd", rd_data, 0);
        end else if (start == 3) begin
            check("ack_hold_state", cap_state, 4);
            check("ack_hold_fv", frame_valid, 1);
        end
        repeat (Div - 1) @(posedge clk);
        #1;
    endtask

    // Reads 98 addresses one per clock, pads to a whole number of sample periods.
    task automatic read_frame();
        logic [3:0] e;
        for (int k = 0; k < 98; k++) begin
            rd_addr = (k < 96) ? 7'(k) : ((k == 96) ? 7'd96 : 7'd127);
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rd[%0d]", rd_addr), rd_data, e);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic capture(input int pat, input int ch, input bit rising, input bit auto_m,
                           input int start);
        int t;
        bit frc;
        trig_ch     = 2'(ch);
        trig_rising = rising;
        auto_mode   = auto_m;
        find_trig(pat, ch, rising, auto_m, t, frc);
        push_frame(pat, t);
        for (int i = 0; i <= t + 63; i++) begin
            tick(gen(pat, i), (i == 0) ? start : 0);
            if (i == 30) check("pre_state", cap_state, 1);
            if (i == 31) check("wait_state", cap_state, 2);
            if (i == t - 1) check("pre_trig_state", cap_state, 2);
            if (i == t) check("post_state", cap_state, 3);
            if (i == t + 62) begin
                check("post_end_state", cap_state, 3);
                check("post_end_fv", frame_valid, 0);
            end
        end
        check("done_state", cap_state, 4);
        check("done_fv", frame_valid, 1);
        check("forced", forced, frc);
        read_frame();
    endtask

    task automatic resync();
        // First edge after reset release sees a speed change and zeroes the divider.
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; speed_switch = 1'b1; logic_in = '0; arm = 1'b0; trig_ch = 2'd1;
        trig_rising = 1'b1; auto_mode = 1'b0; continuous = 1'b0; frame_ack = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", cap_state, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_forced", forced, 0);
        check("rst_rd", rd_data, 0);
        resync();

        // Constant input: PRE for 32 samples, then WAIT forever.
        for (int i = 0; i < 72; i++) begin
            tick(4'h0, (i == 0) ? 1 : 0);
            if (i == 30) check("c0_pre", cap_state, 1);
            if (i == 31) check("c0_wait", cap_state, 2);
            if (i == 71) check("c0_still_wait", cap_state, 2);
        end

        // ch1 rising at sample 49 (arm aborts the WAIT above).
        capture(1, 1, 1'b1, 1'b0, 1);

        // frame_ack with continuous=0 is ignored; frame stays frozen through more ticks.
        continuous = 1'b0;
        tick(4'h5, 3);
        tick(4'hA, 0);
        tick(4'hF, 0);
        check("hold_state", cap_state, 4);
        push_frame(1, 49);
        read_frame();

        // Falling trigger on a channel that only rises: auto timeout forces it.
        capture(2, 2, 1'b0, 1'b1, 1);

        // Trigger after 200 waiting samples, buffer pointer already wrapped.
        capture(3, 0, 1'b1, 1'b0, 1);

        // Continuous re-arm via frame_ack.
        continuous = 1'b1;
        capture(4, 0, 1'b1, 1'b0, 2);
        continuous = 1'b0;

        // Reset in the middle of POST.
        for (int i = 0; i < 50; i++) tick(gen(4, i), (i == 0) ? 1 : 0);
        check("mid_post_state", cap_state, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_post_state", cap_state, 0);
        check("rst_post_fv", frame_valid, 0);
        check("rst_post_rd", rd_data, 0);
        resync();

        // Arm during POST restarts the capture; the new frame must be complete and correct.
        for (int i = 0; i < 50; i++) tick(gen(4, i), (i == 0) ? 1 : 0);
        check("mid_post_state2", cap_state, 3);
        check("mid_post_fv2", frame_valid, 0);
        capture(1, 1, 1'b1, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
